// File: rtl/cpu_defs.sv
// Shared definitions for the 16-bit pipelined CPU: opcode constants, fetch FSM states
// and default address/instruction widths.
package cpu_defs;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;

  // Opcode occupies the top five bits of every instruction word.
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_BNE  = 5'b11001;
  localparam logic [4:0] OP_JMP  = 5'b11010;

  localparam logic [15:0] NOP_WORD  = 16'h0000;
  localparam logic [15:0] HALT_WORD = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory
// address and registers the returned word into the IF/ID register.
module if_stage
  import cpu_defs::*;
#(
  parameter int             AW       = AW_DEF,
  parameter int             IW       = IW_DEF,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] i_addr,
  input  logic [IW-1:0] i_datain,
  output logic [IW-1:0] id_ir,
  output logic [AW-1:0] id_pc,
  output logic          running
);

  if_state_e     state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [IW-1:0] id_ir_reg, id_ir_next;
  logic [AW-1:0] id_pc_reg, id_pc_next;
  logic          halt_fetch;

  assign halt_fetch = (i_datain[IW-1 -: 5] == OP_HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else if (enable) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_EXEC;
      ST_EXEC:   if (!branch_taken && !stall && halt_fetch) state_next = ST_HALTED;
      ST_HALTED: if (branch_taken) state_next = ST_EXEC;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A redirect always wins: it flushes IF/ID even when decode is asking for a stall.
  always_comb begin
    pc_next    = pc_reg;
    id_ir_next = id_ir_reg;
    id_pc_next = id_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        id_ir_next = '0;
      end
      ST_EXEC: begin
        if (branch_taken) begin
          pc_next    = branch_target;
          id_ir_next = '0;
          id_pc_next = '0;
        end else if (!stall) begin
          id_ir_next = i_datain;
          id_pc_next = pc_reg;
          if (!halt_fetch) pc_next = pc_reg + AW'(1);
        end
      end
      ST_HALTED: begin
        if (branch_taken) begin
          pc_next    = branch_target;
          id_ir_next = '0;
          id_pc_next = '0;
        end else if (!stall) begin
          id_ir_next = '0;
        end
      end
      default: begin
        id_ir_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      id_ir_reg <= '0;
      id_pc_reg <= '0;
    end else if (enable) begin
      pc_reg    <= pc_next;
      id_ir_reg <= id_ir_next;
      id_pc_reg <= id_pc_next;
    end
  end

  assign i_addr  = pc_reg;
  assign id_ir   = id_ir_reg;
  assign id_pc   = id_pc_reg;
  assign running = (state_reg == ST_EXEC);

endmodule
